// File: rtl/chip_pkg.sv
// Shared types and truth-table helper for the quad 2-input gate tester.
package chip_pkg;

    // Chip selection codes; values 5..7 are not a supported chip.
    typedef enum logic [2:0] {
        CHIP_7400 = 3'd0,   // NAND
        CHIP_7408 = 3'd1,   // AND
        CHIP_7432 = 3'd2,   // OR
        CHIP_7486 = 3'd3,   // XOR
        CHIP_7402 = 3'd4    // NOR
    } chip_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // AB = 00, 01, 10, 11 applied to every gate in turn.
    localparam int NUM_VECTORS = 4;

    // Output a single healthy gate of the given chip produces for inputs a, b.
    function automatic logic expected_y(chip_t chip, logic a, logic b);
        logic y;
        case (chip)
            CHIP_7400: y = ~(a & b);
            CHIP_7408: y = a & b;
            CHIP_7432: y = a | b;
            CHIP_7486: y = a ^ b;
            CHIP_7402: y = ~(a | b);
            default:   y = 1'b0;
        endcase
        return y;
    endfunction

    // True when the raw selection code names a supported chip.
    function automatic logic chip_sel_valid(logic [2:0] sel);
        return (sel <= 3'd4);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser bringing asynchronous chip outputs into the Clk domain.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Capture the raw input, then re-register it to let metastability resolve.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gate_vector_engine.sv
// Test-vector sequencer for quad 2-input gate chips: sweeps AB over all four
// gates, waits for the chip to settle, samples and compares against the truth
// table, and reports pass / per-gate fail mask / first failing vector.
//
// Handshake: start is a one-cycle request, accepted only while IDLE (ignored
// otherwise); done is a one-cycle strobe marking the cycle in which pass,
// fail_mask, fail_vec and bad_sel are first valid. Those results then hold
// until the next accepted start or Reset.
import chip_pkg::*;

module gate_vector_engine #(
    parameter int SETTLE_CYCLES = 50
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [2:0] chip_sel,
    input  logic [3:0] gate_y,
    output logic [3:0] gate_a,
    output logic [3:0] gate_b,
    output logic       drive_en,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] fail_vec,
    output logic       bad_sel,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    LAST_VEC = 2'(NUM_VECTORS - 1);

    state_t        r_state;
    state_t        w_next;
    chip_t         r_chip;
    logic [1:0]    r_vec;
    logic [CW-1:0] r_cnt;
    logic          r_pass;
    logic [3:0]    r_mask;
    logic [1:0]    r_fail_vec;
    logic          r_bad_sel;

    logic          w_drive;
    logic          w_busy;
    logic          w_done;
    logic          w_sel_ok;
    logic [3:0]    w_y_sync;
    logic [3:0]    w_expected;
    logic [3:0]    w_mismatch;

    sync2 #(.WIDTH(4)) u_sync_y (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_d     (gate_y),
        .o_q     (w_y_sync)
    );

    assign w_sel_ok   = chip_sel_valid(chip_sel);
    // All four gates see the same vector, so they share one expected value.
    assign w_expected = {4{expected_y(r_chip, r_vec[1], r_vec[0])}};
    assign w_mismatch = w_y_sync ^ w_expected;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        w_next  = r_state;
        w_drive = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_sel_ok ? ST_SETTLE : ST_DONE;
                end
            end
            ST_SETTLE: begin
                w_drive = 1'b1;
                w_busy  = 1'b1;
                if (r_cnt == '0) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_drive = 1'b1;
                w_busy  = 1'b1;
                w_next  = (r_vec == LAST_VEC) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Vector index, settle counter and result accumulation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_chip     <= CHIP_7400;
            r_vec      <= '0;
            r_cnt      <= '0;
            r_pass     <= 1'b0;
            r_mask     <= '0;
            r_fail_vec <= '0;
            r_bad_sel  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pass     <= 1'b0;
                        r_mask     <= '0;
                        r_fail_vec <= '0;
                        r_vec      <= '0;
                        if (w_sel_ok) begin
                            r_chip    <= chip_t'(chip_sel);
                            r_cnt     <= RELOAD;
                            r_bad_sel <= 1'b0;
                        end else begin
                            r_bad_sel <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_mask <= r_mask | w_mismatch;
                    // An empty mask means nothing has failed yet this sweep.
                    if ((r_mask == '0) && (w_mismatch != '0)) begin
                        r_fail_vec <= r_vec;
                    end
                    if (r_vec != LAST_VEC) begin
                        r_vec <= r_vec + 1'b1;
                        r_cnt <= RELOAD;
                    end else begin
                        // Pass is settled here so it is already valid alongside done.
                        r_pass <= ((r_mask | w_mismatch) == '0) && !r_bad_sel;
                    end
                end
                ST_DONE: begin
                    r_vec <= '0;
                end
                default: begin
                    r_vec <= '0;
                end
            endcase
        end
    end

    assign gate_a    = w_drive ? {4{r_vec[1]}} : 4'h0;
    assign gate_b    = w_drive ? {4{r_vec[0]}} : 4'h0;
    assign drive_en  = w_drive;
    assign busy      = w_busy;
    assign done      = w_done;
    assign pass      = r_pass;
    assign fail_mask = r_mask;
    assign fail_vec  = r_fail_vec;
    assign bad_sel   = r_bad_sel;
    assign dbg_state = r_state;

endmodule
